ppwm_sequencer: RTL and testbench

- Multi-channel programmable-PWM controller. It owns the free-running period counter and sequences it (start, stop, wrap at a programmable TOP).
- A valid/ready config port writes shadow registers. A commit request copies the shadows into the active set only at a period boundary, so outputs are glitch-free.
- Sits between the chip's config pins and the PWM output pins.

---
 rtl/ppwm_sequencer.sv | 143 ++++++++++++++
 tb/tb_ppwm_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ppwm_sequencer.sv
// Multi-channel programmable PWM sequencer: free-running period counter with
// shadow/active config registers that swap only at a period boundary.
module ppwm_sequencer #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    localparam int ADDR_W = $clog2(NUM_CH + 2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_data,
    output logic [WIDTH-1:0]  count,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_SYNC
    } state_t;

    localparam logic [ADDR_W-1:0] TOP_ADDR  = '0;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_CH + 1);

    state_t            state, state_n;
    logic [WIDTH-1:0]  count_n;
    logic [WIDTH-1:0]  top_shadow, top_active, top_active_n;
    logic [WIDTH-1:0]  duty_shadow   [NUM_CH];
    logic [WIDTH-1:0]  duty_active   [NUM_CH];
    logic [WIDTH-1:0]  duty_active_n [NUM_CH];
    logic [NUM_CH-1:0] pwm_n;
    logic              period_start_n;
    logic              load;
    logic              wr, ctrl_wr, ctrl_run, ctrl_commit, wrap;

    assign cfg_ready   = (state != ST_SYNC);
    assign busy        = (state == ST_SYNC);
    assign wr          = cfg_valid && cfg_ready;
    assign ctrl_wr     = wr && (cfg_addr == CTRL_ADDR);
    assign ctrl_run    = cfg_data[0];
    assign ctrl_commit = cfg_data[1];
    assign wrap        = (count == top_active);

    // NOTE: combinational logic uses blocking '=' and assigns every output a
    // default first, so no path leaves a signal unassigned and infers a latch.
    always_comb begin
        state_n        = state;
        count_n        = count;
        period_start_n = 1'b0;
        load           = 1'b0;
        unique case (state)
            ST_STOP: begin
                count_n = '0;
                if (ctrl_wr) begin
                    load = ctrl_commit;
                    if (ctrl_run) begin
                        state_n        = ST_RUN;
                        period_start_n = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (ctrl_wr && !ctrl_run) begin
                    state_n = ST_STOP;
                    count_n = '0;
                end else begin
                    if (ctrl_wr && ctrl_commit)
                        state_n = ST_SYNC;
                    if (en) begin
                        if (wrap) begin
                            count_n        = '0;
                            period_start_n = 1'b1;
                        end else begin
                            count_n = count + WIDTH'(1);
                        end
                    end
                end
            end
            ST_SYNC: begin
                if (en) begin
                    if (wrap) begin
                        count_n        = '0;
                        period_start_n = 1'b1;
                        load           = 1'b1;
                        state_n        = ST_RUN;
                    end else begin
                        count_n = count + WIDTH'(1);
                    end
                end
            end
            default: state_n = ST_STOP;
        endcase

        // Commit reads the registered shadows, so same-edge shadow writes miss it.
        top_active_n  = load ? top_shadow : top_active;
        duty_active_n = load ? duty_shadow : duty_active;

        pwm_n = '0;
        for (int i = 0; i < NUM_CH; i++)
            pwm_n[i] = (state_n != ST_STOP) && (count_n < duty_active_n[i]);
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values; the duty arrays are reset too, since 0 is their defined value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_STOP;
            count        <= '0;
            pwm_out      <= '0;
            period_start <= 1'b0;
            top_active   <= '1;
            for (int i = 0; i < NUM_CH; i++)
                duty_active[i] <= '0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            pwm_out      <= pwm_n;
            period_start <= period_start_n;
            top_active   <= top_active_n;
            duty_active  <= duty_active_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_shadow <= '1;
            for (int i = 0; i < NUM_CH; i++)
                duty_shadow[i] <= '0;
        end else if (wr) begin
            if (cfg_addr == TOP_ADDR)
                top_shadow <= cfg_data;
            for (int i = 0; i < NUM_CH; i++)
                if (cfg_addr == ADDR_W'(i + 1))
                    duty_shadow[i] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_ppwm_sequencer.sv
// Directed bench for ppwm_sequencer: hand-computed period/duty expectations
// checked with immediate assertions one cycle at a time.
module tb_ppwm_sequencer;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam logic [ADDR_W-1:0] A_TOP  = 3'd0;
    localparam logic [ADDR_W-1:0] A_CTRL = 3'd5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [WIDTH-1:0]  cfg_data = '0;
    logic [WIDTH-1:0]  count;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_start;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;
    int ps_seen;
    logic [NUM_CH-1:0] pwm_any;
    logic [WIDTH-1:0]  duty_m [NUM_CH];

    ppwm_sequencer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .count        (count),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_total++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    function automatic logic [NUM_CH-1:0] exp_pwm(input int k);
        logic [NUM_CH-1:0] r;
        for (int i = 0; i < NUM_CH; i++)
            r[i] = (k < int'(duty_m[i]));
        return r;
    endfunction

    task automatic check_cycle(input int k, input logic eps, input logic ebusy);
        check("count", 32'(count), 32'(k));
        check("period_start", 32'(period_start), 32'(eps));
        check("pwm_out", 32'(pwm_out), 32'(exp_pwm(k)));
        check("busy", 32'(busy), 32'(ebusy));
        check("cfg_ready", 32'(cfg_ready), 32'(!ebusy));
    endtask

    task automatic cfg_write(input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] data);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) duty_m[i] = 8'd0;

        // Reset values
        repeat (2) tick();
        check_cycle(0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // Default TOP=255: 256-cycle period, all outputs low
        en = 1'b1;
        cfg_write(A_CTRL, 8'h01);
        check_cycle(0, 1'b1, 1'b0);
        ps_seen = 0;
        pwm_any = '0;
        repeat (255) begin
            tick();
            ps_seen += int'(period_start);
            pwm_any |= pwm_out;
        end
        check("count_255", 32'(count), 32'd255);
        check("no_ps_midperiod", 32'(ps_seen), 32'd0);
        check("pwm_low_default", 32'(pwm_any), 32'd0);
        tick();
        check_cycle(0, 1'b1, 1'b0);

        // Stop from RUN
        repeat (3) tick();
        check("count_3", 32'(count), 32'd3);
        cfg_write(A_CTRL, 8'h00);
        check_cycle(0, 1'b0, 1'b0);
        tick();
        check_cycle(0, 1'b0, 1'b0);

        // TOP=9, duties 3/0/10/5, commit+run from STOP
        cfg_write(A_TOP, 8'd9);
        cfg_write(3'd1, 8'd3);
        cfg_write(3'd2, 8'd0);
        cfg_write(3'd3, 8'd10);
        cfg_write(3'd4, 8'd5);
        check_cycle(0, 1'b0, 1'b0);
        duty_m[0] = 8'd3; duty_m[1] = 8'd0; duty_m[2] = 8'd10; duty_m[3] = 8'd5;
        cfg_write(A_CTRL, 8'h03);
        for (int k = 0; k < 10; k++) begin
            check_cycle(k, k == 0, 1'b0);
            tick();
        end
        check_cycle(0, 1'b1, 1'b0);

        // Mid-period commit: old duty holds until the wrap
        repeat (4) tick();
        cfg_write(3'd1, 8'd7);
        check_cycle(5, 1'b0, 1'b0);
        cfg_write(A_CTRL, 8'h03);
        check_cycle(6, 1'b0, 1'b1);
        tick();
        check_cycle(7, 1'b0, 1'b1);

        // en low freezes everything, including the pending commit
        en = 1'b0;
        repeat (5) begin
            tick();
            check_cycle(7, 1'b0, 1'b1);
        end
        en = 1'b1;
        for (int k = 8; k < 10; k++) begin
            tick();
            check_cycle(k, 1'b0, 1'b1);
        end
        tick();
        duty_m[0] = 8'd7;
        check_cycle(0, 1'b1, 1'b0);
        for (int k = 1; k < 10; k++) begin
            tick();
            check_cycle(k, 1'b0, 1'b0);
        end
        tick();
        check_cycle(0, 1'b1, 1'b0);

        // Stop then restart without commit: active values kept
        repeat (2) tick();
        cfg_write(A_CTRL, 8'h00);
        check("stop_count", 32'(count), 32'd0);
        check("stop_pwm", 32'(pwm_out), 32'd0);
        check("stop_ps", 32'(period_start), 32'd0);
        tick();
        check("stop_hold", 32'(count), 32'd0);
        cfg_write(A_CTRL, 8'h01);
        check_cycle(0, 1'b1, 1'b0);
        tick();
        check_cycle(1, 1'b0, 1'b0);

        // Async reset while SYNC
        cfg_write(A_CTRL, 8'h03);
        check_cycle(2, 1'b0, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(cfg_ready), 32'd1);
        check("rst_ps", 32'(period_start), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Reloaded shadows: TOP=255, duties 0; unused address ignored
        for (int i = 0; i < NUM_CH; i++) duty_m[i] = 8'd0;
        cfg_write(3'd6, 8'h55);
        cfg_write(A_CTRL, 8'h03);
        check_cycle(0, 1'b1, 1'b0);
        pwm_any = '0;
        repeat (255) begin
            tick();
            pwm_any |= pwm_out;
        end
        check("post_rst_count_255", 32'(count), 32'd255);
        check("post_rst_pwm_low", 32'(pwm_any), 32'd0);
        tick();
        check_cycle(0, 1'b1, 1'b0);

        // TOP=0: one-cycle period
        cfg_write(A_CTRL, 8'h00);
        cfg_write(A_TOP, 8'd0);
        cfg_write(A_CTRL, 8'h03);
        check_cycle(0, 1'b1, 1'b0);
        repeat (3) begin
            tick();
            check_cycle(0, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
